div_unit: RTL and testbench

Iterative 32-bit divider for the RV32M DIV/DIVU/REM/REMU operations in the EX stage, alongside the combinational ALU.
- Takes the same operands, DATA1 and DATA2, and the same 5-bit SELECT as the ALU.
- Holds BUSY high so the hazard unit stalls IF/ID/EX until the quotient or remainder is ready.
- The EX result mux then forwards RESULT to the EX/MEM register in place of the ALU output.
- Radix-2 restoring algorithm, one quotient bit per clock.

---
 rtl/div_unit.sv | 152 +++++++++++++++
 tb/tb_div_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; BUSY stalls the front of the pipe.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [4:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam logic [4:0] OP_DIV  = 5'b01101;
  localparam logic [4:0] OP_DIVU = 5'b01110;
  localparam logic [4:0] OP_REM  = 5'b01111;
  localparam logic [4:0] OP_REMU = 5'b10000;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_dvd;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic            r_qsign;
  logic            r_rsign;
  logic            r_isrem;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  logic            w_valid;
  logic            w_signed;
  logic            w_isrem;
  logic            w_neg1;
  logic            w_neg2;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic            w_dz;
  logic            w_ovf;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_qfin;
  logic [XLEN-1:0] w_rfin;

  assign w_valid  = (SELECT == OP_DIV) || (SELECT == OP_DIVU) ||
                    (SELECT == OP_REM) || (SELECT == OP_REMU);
  assign w_signed = (SELECT == OP_DIV) || (SELECT == OP_REM);
  assign w_isrem  = (SELECT == OP_REM) || (SELECT == OP_REMU);
  assign w_neg1   = w_signed & DATA1[XLEN-1];
  assign w_neg2   = w_signed & DATA2[XLEN-1];
  assign w_abs1   = w_neg1 ? -DATA1 : DATA1;
  assign w_abs2   = w_neg2 ? -DATA2 : DATA2;
  assign w_dz     = (DATA2 == '0);
  assign w_ovf    = w_signed && (DATA1 == MIN_NEG) && (DATA2 == '1);

  // partial remainder never exceeds the divisor, so 33 bits hold the shift
  assign w_shift = {r_rem, r_dvd[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[XLEN];

  assign w_qfin = r_qsign ? -r_quo : r_quo;
  assign w_rfin = r_rsign ? -r_rem : r_rem;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_isrem  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // a START coinciding with DONE belongs to the finishing op
          if (START && !FLUSH && !r_done && w_valid) begin
            r_isrem <= w_isrem;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            if (w_dz || w_ovf) begin
              r_state <= FINISH;
              r_qsign <= 1'b0;
              r_rsign <= 1'b0;
              r_quo   <= w_dz ? '1 : MIN_NEG;
              r_rem   <= w_dz ? DATA1 : '0;
            end else begin
              r_state <= CALC;
              r_dvd   <= w_abs1;
              r_dvs   <= w_abs2;
              r_rem   <= '0;
              r_quo   <= '0;
              r_qsign <= w_neg1 ^ w_neg2;
              r_rsign <= w_neg1;
            end
          end
        end
        CALC: begin
          if (FLUSH) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_dvd <= {r_dvd[XLEN-2:0], 1'b0};
            r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) r_state <= FINISH;
          end
        end
        FINISH: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (!FLUSH) begin
            r_result <= r_isrem ? w_rfin : w_qfin;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign RESULT = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Each step compares against hand-computed quotient/remainder values.
module tb_div_unit;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [4:0]  SELECT;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic        FLUSH;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int vectors;
  int miscompares;

  localparam logic [4:0] DIV  = 5'b01101;
  localparam logic [4:0] DIVU = 5'b01110;
  localparam logic [4:0] REM  = 5'b01111;
  localparam logic [4:0] REMU = 5'b10000;

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .START(START),
    .SELECT(SELECT),
    .DATA1(DATA1),
    .DATA2(DATA2),
    .FLUSH(FLUSH),
    .BUSY(BUSY),
    .DONE(DONE),
    .RESULT(RESULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // issue one op; poke>=0 pulses a stray START at that cycle
  task automatic run_op(input string tag, input logic [4:0] sel,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat,
                        input int poke);
    int cyc;
    int nbusy;
    logic got;
    @(negedge CLK);
    SELECT = sel;
    DATA1  = a;
    DATA2  = b;
    START  = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    cyc   = 0;
    nbusy = 0;
    got   = 1'b0;
    while (!got && cyc < 60) begin
      if (BUSY) nbusy++;
      if (DONE) begin
        got = 1'b1;
      end else begin
        if (cyc == poke) begin
          START  = 1'b1;
          SELECT = DIVU;
          DATA1  = 32'd1;
          DATA2  = 32'd1;
        end
        @(negedge CLK);
        START = 1'b0;
        cyc++;
      end
    end
    chk({tag, " done"}, 32'(got), 32'd1);
    chk({tag, " lat"}, 32'(cyc), 32'(lat));
    chk({tag, " busycyc"}, 32'(nbusy), 32'(lat));
    chk({tag, " busy@done"}, 32'(BUSY), 32'd0);
    chk({tag, " result"}, RESULT, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RESET  = 1'b1;
    START  = 1'b0;
    SELECT = 5'b0;
    DATA1  = '0;
    DATA2  = '0;
    FLUSH  = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset busy", 32'(BUSY), 32'd0);
    chk("reset done", 32'(DONE), 32'd0);
    chk("reset result", RESULT, 32'd0);
    RESET = 1'b0;

    run_op("div 100/7", DIV, 32'd100, 32'd7, 32'd14, 33, -1);
    // START in the DONE cycle must be ignored
    START  = 1'b1;
    SELECT = DIVU;
    DATA1  = 32'd5;
    DATA2  = 32'd7;
    @(negedge CLK);
    START = 1'b0;
    chk("start@done busy", 32'(BUSY), 32'd0);
    chk("start@done result", RESULT, 32'd14);

    run_op("rem 100/7", REM, 32'd100, 32'd7, 32'd2, 33, -1);
    run_op("div -20/6", DIV, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, 33, -1);
    run_op("rem -20/6", REM, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFE, 33, -1);
    run_op("div 20/-6", DIV, 32'd20, 32'hFFFFFFFA, 32'hFFFFFFFD, 33, -1);
    run_op("rem 20/-6", REM, 32'd20, 32'hFFFFFFFA, 32'd2, 33, -1);
    run_op("divu max/2", DIVU, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 33, -1);
    run_op("remu max/2", REMU, 32'hFFFFFFFF, 32'd2, 32'd1, 33, -1);
    run_op("divu 5/7", DIVU, 32'd5, 32'd7, 32'd0, 33, -1);
    run_op("remu 5/7", REMU, 32'd5, 32'd7, 32'd5, 33, -1);
    run_op("div 31/0", DIV, 32'd31, 32'd0, 32'hFFFFFFFF, 1, -1);
    run_op("rem 31/0", REM, 32'd31, 32'd0, 32'd31, 1, -1);
    run_op("divu 31/0", DIVU, 32'd31, 32'd0, 32'hFFFFFFFF, 1, -1);
    run_op("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, -1);
    run_op("rem ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, -1);
    run_op("divu big", DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33, -1);
    run_op("div restart", DIV, 32'd100, 32'd7, 32'd14, 33, 5);

    // invalid op code
    @(negedge CLK);
    SELECT = 5'b00001;
    DATA1  = 32'd9;
    DATA2  = 32'd3;
    START  = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("badsel busy", 32'(BUSY), 32'd0);
    repeat (3) @(negedge CLK);
    chk("badsel done", 32'(DONE), 32'd0);
    chk("badsel result", RESULT, 32'd14);

    // FLUSH in IDLE blocks a same-cycle START
    SELECT = DIV;
    DATA1  = 32'd50;
    DATA2  = 32'd5;
    START  = 1'b1;
    FLUSH  = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    FLUSH = 1'b0;
    chk("idleflush busy", 32'(BUSY), 32'd0);

    // FLUSH mid CALC
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    chk("flush busy", 32'(BUSY), 32'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (DONE) seen++;
        @(negedge CLK);
      end
      chk("flush nodone", 32'(seen), 32'd0);
    end
    chk("flush result", RESULT, 32'd14);

    // asynchronous reset between edges mid CALC
    SELECT = DIVU;
    DATA1  = 32'd1000;
    DATA2  = 32'd3;
    START  = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (6) @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("areset busy", 32'(BUSY), 32'd0);
    chk("areset done", 32'(DONE), 32'd0);
    chk("areset result", RESULT, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    run_op("div 32/2", DIV, 32'd32, 32'd2, 32'd16, 33, -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
